// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window generator and sobel_calc.
package sobel_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned WIN_N      = 9;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Row-major 3x3 window indices; D_BR is always the newest pixel.
  localparam int unsigned D_TL = 0;
  localparam int unsigned D_TM = 1;
  localparam int unsigned D_TR = 2;
  localparam int unsigned D_ML = 3;
  localparam int unsigned D_C  = 4;
  localparam int unsigned D_MR = 5;
  localparam int unsigned D_BL = 6;
  localparam int unsigned D_BM = 7;
  localparam int unsigned D_BR = 8;

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: asynchronous read, registered write, so a read and
// write at the same address return the old contents.
module sobel_line_buf #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 interior windows from a raster pixel stream for sobel_calc.
// Define SOBEL_WIN_STATUS_EN to add the per-frame window counter win_count_o.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] d0_o,
  output logic [DATA_W-1:0] d1_o,
  output logic [DATA_W-1:0] d2_o,
  output logic [DATA_W-1:0] d3_o,
  output logic [DATA_W-1:0] d4_o,
  output logic [DATA_W-1:0] d5_o,
  output logic [DATA_W-1:0] d6_o,
  output logic [DATA_W-1:0] d7_o,
  output logic [DATA_W-1:0] d8_o,
  output logic              done_o,
`ifdef SOBEL_WIN_STATUS_EN
  output logic [31:0]       win_count_o,
`endif
  output logic              frame_done_o
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  state_e            state_q;
  logic [DATA_W-1:0] win_q   [WIN_N];
  logic [DATA_W-1:0] win_nxt [WIN_N];
  logic [DATA_W-1:0] dout_q  [WIN_N];
  logic              done_q;
  logic              frame_done_q;
  logic [DATA_W-1:0] top_c;
  logic [DATA_W-1:0] mid_c;
  logic              col_last_c;
  logic              row_last_c;
  logic              emit_c;

  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W),
    .ADDR_W(COL_W)
  ) u_lb1 (
    .clk    (clk),
    .we     (valid_i & ~rst),
    .addr   (col_q),
    .wdata  (pixel_i),
    .rdata_c(mid_c)
  );

  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_W),
    .ADDR_W(COL_W)
  ) u_lb2 (
    .clk    (clk),
    .we     (valid_i & ~rst),
    .addr   (col_q),
    .wdata  (mid_c),
    .rdata_c(top_c)
  );

  assign col_last_c = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last_c = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // RUN implies row >= 2; columns 0 and 1 hold data from the previous line.
  assign emit_c     = valid_i && (state_q == ST_RUN) && (col_q >= COL_W'(2));

  // Shift window left by one column and append {top, mid, new pixel}.
  always_comb begin
    win_nxt[D_TL] = win_q[D_TM];
    win_nxt[D_TM] = win_q[D_TR];
    win_nxt[D_TR] = top_c;
    win_nxt[D_ML] = win_q[D_C];
    win_nxt[D_C]  = win_q[D_MR];
    win_nxt[D_MR] = mid_c;
    win_nxt[D_BL] = win_q[D_BM];
    win_nxt[D_BM] = win_q[D_BR];
    win_nxt[D_BR] = pixel_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= ST_FILL;
      win_q        <= '{default: '0};
      dout_q       <= '{default: '0};
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      if (valid_i) begin
        win_q <= win_nxt;
        if (col_last_c) begin
          col_q <= '0;
          row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
        case (state_q)
          ST_FILL: if (col_last_c && row_q == ROW_W'(1)) state_q <= ST_RUN;
          ST_RUN:  if (col_last_c && row_last_c)         state_q <= ST_FILL;
          default: state_q <= ST_FILL;
        endcase
        if (emit_c) begin
          dout_q       <= win_nxt;
          done_q       <= 1'b1;
          frame_done_q <= col_last_c && row_last_c;
        end
      end
    end
  end

`ifdef SOBEL_WIN_STATUS_EN
  logic [31:0] win_count_q;

  // Counts windows in the current frame; clears once the frame has closed.
  always_ff @(posedge clk) begin
    if (rst || frame_done_q) win_count_q <= '0;
    else if (emit_c)         win_count_q <= win_count_q + 32'd1;
  end

  assign win_count_o = win_count_q;
`endif

  assign d0_o         = dout_q[D_TL];
  assign d1_o         = dout_q[D_TM];
  assign d2_o         = dout_q[D_TR];
  assign d3_o         = dout_q[D_ML];
  assign d4_o         = dout_q[D_C];
  assign d5_o         = dout_q[D_MR];
  assign d6_o         = dout_q[D_BL];
  assign d7_o         = dout_q[D_BM];
  assign d8_o         = dout_q[D_BR];
  assign done_o       = done_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image.
module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pixel_i;
  logic          valid_i;
  logic [DW-1:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic          done_o;
  logic          frame_done_o;
`ifdef SOBEL_WIN_STATUS_EN
  logic [31:0]   win_count_o;
`endif

  logic [DW-1:0] dv       [9];
  logic [DW-1:0] hold_exp [9];
  int            checks = 0;
  int            errors = 0;
  int            exp_cnt = 0;
  bit            prev_fd = 1'b0;

  always #5 clk = ~clk;

  sobel_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_i     (pixel_i),
    .valid_i     (valid_i),
    .d0_o        (d0_o),
    .d1_o        (d1_o),
    .d2_o        (d2_o),
    .d3_o        (d3_o),
    .d4_o        (d4_o),
    .d5_o        (d5_o),
    .d6_o        (d6_o),
    .d7_o        (d7_o),
    .d8_o        (d8_o),
    .done_o      (done_o),
`ifdef SOBEL_WIN_STATUS_EN
    .win_count_o (win_count_o),
`endif
    .frame_done_o(frame_done_o)
  );

  assign dv[0] = d0_o;
  assign dv[1] = d1_o;
  assign dv[2] = d2_o;
  assign dv[3] = d3_o;
  assign dv[4] = d4_o;
  assign dv[5] = d5_o;
  assign dv[6] = d6_o;
  assign dv[7] = d7_o;
  assign dv[8] = d8_o;

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; pixel_i = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      hold_exp[4'(k)] = '0;
      checks++;
      if (dv[4'(k)] !== 8'd0) begin
        errors++; $display("FAIL reset_d%0d got %0d exp 0", k, dv[4'(k)]);
      end
    end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++;
    if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done_o); end
`ifdef SOBEL_WIN_STATUS_EN
    checks++;
    if (win_count_o !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", win_count_o); end
`endif
    exp_cnt = 0; prev_fd = 1'b0;
    rst = 1'b0;
  endtask

  // Feeds one frame base..base+15; optional 3-cycle gaps after pixels 5 and 11.
  task automatic test_full_frame(input int base, input bit stall, input bit idle_end);
    int n_done;
    n_done = 0;
    for (int p = 0; p < W * H; p++) begin
      int r;
      int c;
      bit ed;
      r = p / W; c = p % W;
      pixel_i = DW'(base + p); valid_i = 1'b1;
      @(posedge clk); #1;
      ed = (r >= 2) && (c >= 2);
      if (prev_fd) exp_cnt = 0;
      if (ed) exp_cnt++;
      prev_fd = (p == W * H - 1);
      if (ed) begin
        for (int k = 0; k < 9; k++)
          hold_exp[4'(k)] = DW'(base + (r - 2 + k / 3) * W + (c - 2 + k % 3));
      end
      if (done_o === 1'b1) n_done++;
      checks++;
      if (done_o !== ed) begin
        errors++; $display("FAIL done base=%0d p=%0d got %b exp %b", base, p, done_o, ed);
      end
      checks++;
      if (frame_done_o !== prev_fd) begin
        errors++; $display("FAIL frame_done base=%0d p=%0d got %b exp %b", base, p, frame_done_o, prev_fd);
      end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (dv[4'(k)] !== hold_exp[4'(k)]) begin
          errors++; $display("FAIL win base=%0d p=%0d d%0d got %0d exp %0d", base, p, k, dv[4'(k)], hold_exp[4'(k)]);
        end
      end
`ifdef SOBEL_WIN_STATUS_EN
      checks++;
      if (win_count_o !== 32'(exp_cnt)) begin
        errors++; $display("FAIL count base=%0d p=%0d got %0d exp %0d", base, p, win_count_o, exp_cnt);
      end
`endif
      if (stall && (p == 4 || p == 10)) begin
        valid_i = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          checks++;
          if (done_o !== 1'b0) begin errors++; $display("FAIL gap_done p=%0d got %b exp 0", p, done_o); end
          for (int k = 0; k < 9; k++) begin
            checks++;
            if (dv[4'(k)] !== hold_exp[4'(k)]) begin
              errors++; $display("FAIL gap_hold p=%0d d%0d got %0d exp %0d", p, k, dv[4'(k)], hold_exp[4'(k)]);
            end
          end
        end
      end
    end
    checks++;
    if (n_done != (W - 2) * (H - 2)) begin
      errors++; $display("FAIL window_total base=%0d got %0d exp %0d", base, n_done, (W - 2) * (H - 2));
    end
    if (idle_end) begin
      valid_i = 1'b0;
      @(posedge clk); #1;
      if (prev_fd) exp_cnt = 0;
      prev_fd = 1'b0;
      checks++;
      if (done_o !== 1'b0 || frame_done_o !== 1'b0) begin
        errors++; $display("FAIL idle_strobes got done=%b fd=%b exp 0", done_o, frame_done_o);
      end
`ifdef SOBEL_WIN_STATUS_EN
      checks++;
      if (win_count_o !== 32'(exp_cnt)) begin
        errors++; $display("FAIL count_clear got %0d exp %0d", win_count_o, exp_cnt);
      end
`endif
    end
  endtask

  task automatic test_stalls();
    test_full_frame(1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    test_full_frame(1, 1'b0, 1'b0);
    test_full_frame(101, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    for (int p = 0; p < 7; p++) begin
      pixel_i = DW'(1 + p); valid_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (done_o !== 1'b0) begin errors++; $display("FAIL pre_reset_done p=%0d got %b exp 0", p, done_o); end
    end
    valid_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      hold_exp[4'(k)] = '0;
      checks++;
      if (dv[4'(k)] !== 8'd0) begin
        errors++; $display("FAIL midrst_d%0d got %0d exp 0", k, dv[4'(k)]);
      end
    end
    checks++;
    if (done_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL midrst_strobes got done=%b fd=%b exp 0", done_o, frame_done_o);
    end
    exp_cnt = 0; prev_fd = 1'b0;
    test_full_frame(1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_frame(1, 1'b0, 1'b1);
    test_stalls();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
